// File: rtl/cashreg_support.sv
// Support logic for the cash-register datapath: free-running clock divider,
// W-bit ripple-carry accumulator adder, and a 4-digit seven-segment decoder.
module cashreg_support #(
  parameter int W     = 8,
  parameter int DIV_W = 37
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  output logic [DIV_W-1:0] clk_out,
  input  logic [W-1:0]     add_a,
  input  logic [W-1:0]     add_b,
  input  logic             add_cin,
  output logic [W-1:0]     add_sum,
  output logic             add_ovf,
  input  logic [W-1:0]     disp_val,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic             TooLarge
);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  logic [DIV_W-1:0] r_count;
  logic [W:0]       w_carry;
  logic [W-1:0]     w_sum;
  logic [15:0]      w_val16;
  logic [15:0]      w_bcd;
  logic [3:0]       w_digit0, w_digit1, w_digit2, w_digit3;
  logic             w_blank1, w_blank2, w_blank3;
  logic             w_too_large;

  // Consumers tap individual bits of the count as slow clocks.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign clk_out = r_count;

  assign w_carry[0] = add_cin;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign w_sum[gi]       = add_a[gi] ^ add_b[gi] ^ w_carry[gi];
    assign w_carry[gi + 1] = (add_a[gi] & add_b[gi]) |
                             (w_carry[gi] & (add_a[gi] ^ add_b[gi]));
  end

  assign add_sum = w_sum;
  assign add_ovf = w_carry[W];

  // Shift-add-3 conversion; only four digits are kept because anything that
  // would need a fifth digit is shown as dashes anyway.
  function automatic logic [15:0] bin2bcd(input logic [15:0] bin);
    logic [15:0] bcd;
    bcd = '0;
    for (int i = 15; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (bcd[4*d +: 4] >= 4'd5) begin
          bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
      end
      bcd = {bcd[14:0], bin[i]};
    end
    return bcd;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  always_comb begin
    w_val16 = '0;
    w_val16[W-1:0] = disp_val;
  end

  assign w_bcd    = bin2bcd(w_val16);
  assign w_digit0 = w_bcd[3:0];
  assign w_digit1 = w_bcd[7:4];
  assign w_digit2 = w_bcd[11:8];
  assign w_digit3 = w_bcd[15:12];

  // A digit blanks only when it and every digit above it are zero.
  assign w_blank3 = (w_digit3 == 4'd0);
  assign w_blank2 = w_blank3 && (w_digit2 == 4'd0);
  assign w_blank1 = w_blank2 && (w_digit1 == 4'd0);

  if (W > 13) begin : g_range_check
    assign w_too_large = (w_val16 > 16'd9999);
  end else begin : g_no_range_check
    assign w_too_large = 1'b0;
  end

  assign TooLarge = w_too_large;

  always_comb begin
    HEX0 = seg7(w_digit0);
    HEX1 = w_blank1 ? SEG_BLANK : seg7(w_digit1);
    HEX2 = w_blank2 ? SEG_BLANK : seg7(w_digit2);
    HEX3 = w_blank3 ? SEG_BLANK : seg7(w_digit3);
    if (w_too_large) begin
      HEX0 = SEG_DASH;
      HEX1 = SEG_DASH;
      HEX2 = SEG_DASH;
      HEX3 = SEG_DASH;
    end
  end

endmodule

// File: tb/tb_cashreg_support.sv
// Bench for cashreg_support: an 8-bit build with a 4-bit divider and a
// 16-bit build with the full-width divider, compared against a decimal model.
module tb_cashreg_support;

  logic        clock;
  logic        resetN;
  logic [3:0]  count8;
  logic [36:0] count16;
  logic [7:0]  a8, b8, sum8, disp8;
  logic [15:0] a16, b16, sum16, disp16;
  logic        cin, ovf8, ovf16, too8, too16;
  logic [6:0]  hex8 [4];
  logic [6:0]  hex16 [4];

  int totalCount;
  int badCount;
  logic [6:0] segTable [10];

  cashreg_support #(.W(8), .DIV_W(4)) u_dut8 (
    .CLOCK_50(clock), .RESET_N(resetN), .clk_out(count8),
    .add_a(a8), .add_b(b8), .add_cin(cin), .add_sum(sum8), .add_ovf(ovf8),
    .disp_val(disp8), .HEX0(hex8[0]), .HEX1(hex8[1]), .HEX2(hex8[2]),
    .HEX3(hex8[3]), .TooLarge(too8)
  );

  cashreg_support #(.W(16), .DIV_W(37)) u_dut16 (
    .CLOCK_50(clock), .RESET_N(resetN), .clk_out(count16),
    .add_a(a16), .add_b(b16), .add_cin(cin), .add_sum(sum16), .add_ovf(ovf16),
    .disp_val(disp16), .HEX0(hex16[0]), .HEX1(hex16[1]), .HEX2(hex16[2]),
    .HEX3(hex16[3]), .TooLarge(too16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int a, input int b, input int c, input int disp);
    a16    = a[15:0];
    b16    = b[15:0];
    a8     = a[7:0];
    b8     = b[7:0];
    cin    = c[0];
    disp16 = disp[15:0];
    disp8  = disp[7:0];
    #1;
  endtask

  // Decimal reference: {TooLarge, HEX3, HEX2, HEX1, HEX0}.
  function automatic logic [28:0] modelDisplay(input int v);
    logic [28:0] r;
    int pow;
    if (v > 9999) return {1'b1, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    r = '0;
    pow = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0 && v < pow) r[7*i +: 7] = 7'h7F;
      else r[7*i +: 7] = segTable[(v / pow) % 10];
      pow = pow * 10;
    end
    return r;
  endfunction

  task automatic checkModel(input int a, input int b, input int c, input int disp);
    int total8, total16;
    total8  = (a % 256) + (b % 256) + c;
    total16 = (a % 65536) + (b % 65536) + c;
    checkOutput("sum8",  64'(sum8),  64'(total8 % 256));
    checkOutput("ovf8",  64'(ovf8),  64'(total8 >= 256));
    checkOutput("sum16", 64'(sum16), 64'(total16 % 65536));
    checkOutput("ovf16", 64'(ovf16), 64'(total16 >= 65536));
    checkOutput("disp8",  64'({too8, hex8[3], hex8[2], hex8[1], hex8[0]}),
                64'(modelDisplay(disp % 256)));
    checkOutput("disp16", 64'({too16, hex16[3], hex16[2], hex16[1], hex16[0]}),
                64'(modelDisplay(disp % 65536)));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int edges;
    int a, b, c, d;
    segTable = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    totalCount = 0;
    badCount   = 0;
    resetN = 1'b0;
    applyStimulus(0, 0, 0, 0);

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("resetHold8",  64'(count8),  64'd0);
    checkOutput("resetHold16", 64'(count16), 64'd0);

    resetN = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clock);
      #1;
      checkOutput("count8",  64'(count8),  64'(n % 16));
      checkOutput("count16", 64'(count16), 64'(n));
    end

    @(posedge clock);
    #2 resetN = 1'b0;
    #1;
    checkOutput("asyncReset8",  64'(count8),  64'd0);
    checkOutput("asyncReset16", 64'(count16), 64'd0);
    @(negedge clock);
    resetN = 1'b1;

    edges = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      edges++;
      checkOutput("wrap8",   64'(count8),  64'(edges % 16));
      checkOutput("bit3",    64'(count8[3]), 64'((edges / 8) % 2));
      checkOutput("count16", 64'(count16), 64'(edges));
    end

    applyStimulus(200, 100, 0, 0);
    checkOutput("add200+100", 64'({ovf8, sum8}), 64'({1'b1, 8'd44}));
    applyStimulus(100, 27, 1, 255);
    checkOutput("add100+27+1", 64'({ovf8, sum8}), 64'({1'b0, 8'd128}));
    checkOutput("hex255", 64'({hex8[3], hex8[2], hex8[1], hex8[0]}),
                64'({7'h7F, 7'h24, 7'h12, 7'h12}));
    applyStimulus(255, 0, 1, 105);
    checkOutput("add255+0+1", 64'({ovf8, sum8}), 64'({1'b1, 8'd0}));
    checkOutput("hex105", 64'({hex8[3], hex8[2], hex8[1], hex8[0]}),
                64'({7'h7F, 7'h79, 7'h40, 7'h12}));
    applyStimulus(0, 0, 0, 0);
    checkOutput("hex0", 64'({too8, hex8[3], hex8[2], hex8[1], hex8[0]}),
                64'({1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
    applyStimulus(0, 0, 0, 9999);
    checkOutput("hex9999", 64'({too16, hex16[3], hex16[2], hex16[1], hex16[0]}),
                64'({1'b0, 7'h10, 7'h10, 7'h10, 7'h10}));
    applyStimulus(0, 0, 0, 12345);
    checkOutput("hex12345", 64'({too16, hex16[3], hex16[2], hex16[1], hex16[0]}),
                64'({1'b1, 7'h3F, 7'h3F, 7'h3F, 7'h3F}));

    for (int v = 0; v < 256; v++) begin
      a = $urandom_range(0, 65535);
      b = $urandom_range(0, 65535);
      c = $urandom_range(0, 1);
      applyStimulus(a, b, c, v);
      checkModel(a, b, c, v);
    end

    for (int i = 0; i < 300; i++) begin
      a = (i % 5 == 0) ? 65535 : $urandom_range(0, 65535);
      b = $urandom_range(0, 65535);
      c = $urandom_range(0, 1);
      d = (i % 3 == 0) ? $urandom_range(9990, 10010) : $urandom_range(0, 65535);
      applyStimulus(a, b, c, d);
      checkModel(a, b, c, d);
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
